// File: rtl/multi_debouncer_pkg.sv
// Shared definitions for the multi-channel key conditioner.
// State encoding is fixed so other blocks and debug tools can decode it.
package multi_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_PRESS   = 2'b01,
        PRESSED      = 2'b10,
        WAIT_RELEASE = 2'b11
    } state_t;

endpackage

// File: rtl/D_FFRE.sv
// Generic register with synchronous active-high reset and clock enable.
module D_FFRE #(
    parameter int            W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/debounce_channel.sv
// One key channel: 2-flop synchroniser, lock-out debounce FSM, hold timer.
// The release pulse is named rel because release is a reserved word.
module debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int CNT_W      = 3,
    parameter int HOLD_W     = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic key,
    output logic level,
    output logic press,
    output logic rel,
    output logic hold
);

    localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = {{(HOLD_W-1){1'b1}}, 1'b0};

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic sync_p0;
    logic sync_p1;
    logic act;

    // Synchroniser resets to the idle key level so no press appears after reset.
    D_FFRE #(.W(1), .RST_VAL(ACTIVE_LOW)) u_sync_p0 (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (key),
        .q     (sync_p0)
    );

    D_FFRE #(.W(1), .RST_VAL(ACTIVE_LOW)) u_sync_p1 (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (sync_p0),
        .q     (sync_p1)
    );

    assign act = ACTIVE_LOW ? ~sync_p1 : sync_p1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hcnt  <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            hold  <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            hold  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    hcnt <= '0;
                    if (act) begin
                        state <= WAIT_PRESS;
                        press <= 1'b1;
                        level <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    hcnt <= '0;
                    if (cnt == '1) begin
                        state <= PRESSED;
                    end else if (en) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    cnt <= '0;
                    // hold fires only on the tick that lands exactly on all-ones
                    if (en) begin
                        hcnt <= sat_inc(hcnt);
                        if (hcnt == HOLD_LAST) begin
                            hold <= 1'b1;
                        end
                    end
                    if (!act) begin
                        state <= WAIT_RELEASE;
                        rel   <= 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    hcnt <= '0;
                    if (cnt == '1) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end else if (en) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_debouncer.sv
// N independent key conditioners sharing one clock and one slow tick.
// The release pulse bus is named rel because release is a reserved word.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int N          = 4,
    parameter int CNT_W      = 3,
    parameter int HOLD_W     = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] hold
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .CNT_W      (CNT_W),
            .HOLD_W     (HOLD_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .key   (in[i]),
            .level (level[i]),
            .press (press[i]),
            .rel   (rel[i]),
            .hold  (hold[i])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with N=4, CNT_W=3, HOLD_W=8, active-low keys.
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] in_v;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] hold;

    int errors = 0;
    int checks = 0;
    int press_cnt [4];
    int rel_cnt   [4];
    int hold_cnt  [4];

    multi_debouncer #(.N(4), .CNT_W(3), .HOLD_W(8), .ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .in    (in_v),
        .level (level),
        .press (press),
        .rel   (rel),
        .hold  (hold)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            hold_cnt[i]  = 0;
        end
    end

    // Pulse counters: a pulse registered on one edge is counted on the next.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] <= press_cnt[i] + int'(press[i]);
            rel_cnt[i]   <= rel_cnt[i]   + int'(rel[i]);
            hold_cnt[i]  <= hold_cnt[i]  + int'(hold[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            en = 1'b1;
            step(1);
            en = 1'b0;
            step(1);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        in_v  = 4'hF;

        // Reset held with keys idle
        step(20);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_press", 32'(press), 32'h0);
        chk("rst_rel",   32'(rel),   32'h0);
        chk("rst_hold",  32'(hold),  32'h0);
        reset = 1'b0;
        step(5);
        chk("post_rst_no_press", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'h0);
        chk("post_rst_level", 32'(level), 32'h0);

        // Channel 0 press with exact latency, then bounces during lock-out
        in_v[0] = 1'b0;
        step(2);
        chk("p0_lat_early", 32'(press), 32'h0);
        step(1);
        chk("p0_lat", 32'(press), 32'h1);
        chk("p0_level", 32'(level), 32'h1);
        for (int b = 0; b < 5; b++) begin
            in_v[0] = 1'b1;
            step(1);
            in_v[0] = 1'b0;
            if (b < 3) begin
                en = 1'b1;
                step(1);
                en = 1'b0;
            end else begin
                step(1);
            end
        end
        ticks(4);
        step(2);
        chk("p0_single_press", 32'(press_cnt[0]), 32'd1);
        chk("p0_level_held", 32'(level), 32'h1);

        // Channel 0 release: exact latency proves the FSM sat in PRESSED
        in_v[0] = 1'b1;
        step(2);
        chk("r0_lat_early", 32'(rel), 32'h0);
        step(1);
        chk("r0_lat", 32'(rel), 32'h1);
        chk("r0_level_still", 32'(level), 32'h1);
        for (int b = 0; b < 5; b++) begin
            in_v[0] = 1'b0;
            step(1);
            in_v[0] = 1'b1;
            if (b < 3) begin
                en = 1'b1;
                step(1);
                en = 1'b0;
            end else begin
                step(1);
            end
        end
        ticks(3);
        chk("r0_level_tick6", 32'(level), 32'h1);
        ticks(1);
        step(1);
        chk("r0_level_low", 32'(level), 32'h0);
        step(3);
        chk("r0_single_rel", 32'(rel_cnt[0]), 32'd1);
        chk("r0_no_repress", 32'(press_cnt[0]), 32'd1);

        // Channel 1 long press: hold at tick 255 of PRESSED only
        in_v[1] = 1'b0;
        step(3);
        chk("p1_press", 32'(press), 32'h2);
        ticks(7);
        ticks(254);
        step(1);
        chk("h1_before", 32'(hold_cnt[1]), 32'd0);
        ticks(1);
        step(1);
        chk("h1_at_255", 32'(hold_cnt[1]), 32'd1);
        ticks(45);
        chk("h1_once", 32'(hold_cnt[1]), 32'd1);
        chk("h1_level", 32'(level), 32'h2);
        chk("h1_other_ch", 32'(hold_cnt[0] + hold_cnt[2] + hold_cnt[3]), 32'd0);
        in_v[1] = 1'b1;
        step(3);
        chk("r1_lat", 32'(rel), 32'h2);
        ticks(8);
        step(2);
        chk("r1_level", 32'(level), 32'h0);

        // Channels 0 and 3 together, released while still locked out
        in_v = 4'b0110;
        step(3);
        chk("p03_press", 32'(press), 32'h9);
        chk("p03_level", 32'(level), 32'h9);
        in_v = 4'hF;
        ticks(7);
        chk("r03_not_yet", 32'(rel), 32'h0);
        step(1);
        chk("r03_rel", 32'(rel), 32'h9);
        ticks(8);
        step(2);
        chk("r03_level", 32'(level), 32'h0);
        chk("p3_count", 32'(press_cnt[3]), 32'd1);

        // Reset during WAIT_PRESS with key held
        in_v = 4'b1011;
        step(3);
        chk("p2_press", 32'(press), 32'h4);
        ticks(2);
        reset = 1'b1;
        step(1);
        chk("rst_mid_level", 32'(level), 32'h0);
        chk("rst_mid_press", 32'(press), 32'h0);
        reset = 1'b0;
        step(2);
        chk("rst_mid_early", 32'(press), 32'h0);
        step(1);
        chk("rst_mid_repress", 32'(press), 32'h4);
        chk("rst_mid_relevel", 32'(level), 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised N-channel push-button conditioner; successor to the single-input debouncer. Each channel synchronises a raw active-low key, debounces it with a lock-out timer clocked by the shared slow tick `en`, and produces a clean level plus one-cycle press, release and long-press (hold) pulses. Sits between the board keys and the player control FSM, so the controller never has to edge-detect.

## Interface
- `N`, 4, number of independent channels
- `CNT_W`, 3, lock-out timer width; settle time = 2^CNT_W − 1 `en` ticks
- `HOLD_W`, 8, long-press timer width; hold threshold = 2^HOLD_W − 1 `en` ticks
- `ACTIVE_LOW`, 1, 1: key pressed when `in` = 0; 0: pressed when `in` = 1

- `clk` input 1 system clock; one clock, all logic on rising edge
- `reset` input 1 synchronous, active-high reset
- `en` input 1 one-`clk`-wide tick from the shared prescaler (≈1.31 ms period)
- `in` input N raw asynchronous key inputs
- `level` output N debounced pressed level, 1 = pressed
- `press` output N one-`clk` pulse on accepted press
- `release` output N one-`clk` pulse on accepted release
- `hold` output N one-`clk` pulse once per press after hold threshold

## Operation
- Per channel: 2-flop synchroniser, then polarity normalisation (`act` = pressed).
- FSM states: IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
  - IDLE: lock-out timer cleared; `act` → WAIT_PRESS, assert `press`.
  - WAIT_PRESS: timer counts on `en`; `act` ignored (bounce lock-out); timer all-ones → PRESSED.
  - PRESSED: timer cleared; hold timer counts on `en`; `!act` → WAIT_RELEASE, assert `release`.
  - WAIT_RELEASE: timer counts on `en`; `act` ignored; timer all-ones → IDLE.
- `level` = 1 in WAIT_PRESS, PRESSED, WAIT_RELEASE; 0 in IDLE (immediate-response debounce).
- Hold timer: cleared in every state but PRESSED; saturates at all-ones; `hold` pulses on the edge it first reaches all-ones, never again until re-entering PRESSED.
- Channels fully independent; simultaneous events on different channels all reported in the same cycle.
- `en` held low: timers freeze, FSM can still leave IDLE/PRESSED on input change.

## Timing
- Reset: state IDLE, both timers 0, `level`/`press`/`release`/`hold` = 0, synchroniser flops = inactive level (1 if `ACTIVE_LOW`), so no spurious press after reset.
- Reset mid-operation overrides everything on that edge; pulses in flight are dropped.
- `in` change set up before edge k: synchroniser stage 2 at edge k+1, FSM transition and `press`/`release` registered at edge k+2, visible cycle after k+2; `level` follows same edge.
- Lock-out exit on the `clk` edge where timer = 2^CNT_W − 1 (counted in `en` ticks, not `clk`).
- Release during WAIT_PRESS: still enters PRESSED, then WAIT_RELEASE next edge with `release` pulse; press/release always alternate.
- Release on the same edge hold timer saturates: `hold` and `release` both pulse.
- All outputs registered; no combinational path `in` → outputs.

## Structure
- Shared package: 2-bit state encoding constants (IDLE=00, WAIT_PRESS=01, PRESSED=10, WAIT_RELEASE=11).
- Sub-module `debounce_channel` (one channel: synchroniser, FSM, both timers, output regs), instantiated N times in a generate loop; registers built from the existing `D_FFRE` flop.

## Test plan
- Reset with `in` = all ones, hold 20 cycles → all outputs 0, no pulses.
- Channel 0 low with 5 bounces in first 3 ticks, CNT_W=3 → exactly one `press[0]` 3 clk after first low, `level[0]` high, PRESSED after 7 `en` ticks.
- Release channel 0 with bounces → one `release[0]`, `level[0]` low after 7 ticks, no second press.
- Hold channel 1 for 300 ticks, HOLD_W=8 → single `hold[1]` at tick 255 of PRESSED, none afterwards.
- Press channels 0 and 3 on same cycle → `press[0]` and `press[3]` same cycle; others 0.
- Assert `reset` during WAIT_PRESS → next cycle IDLE, `level` 0; key still held → new `press` 3 clk after reset drops.
